// File: rtl/wakeup_cam_ready_pkg.sv
// Issue-queue shared types and default sizing for the wakeup CAM.
package wakeup_cam_ready_pkg;

  localparam int unsigned IqRport = 4;
  localparam int unsigned IqWport = 4;
  localparam int unsigned IqDepth = 32;
  localparam int unsigned IqIndex = 5;
  localparam int unsigned IqWidth = 7;
  localparam int unsigned IqNsrc  = 2;

  typedef logic [IqWidth-1:0] phys_tag_t;
  typedef logic [IqIndex-1:0] iq_index_t;

endpackage

// File: rtl/wakeup_cam_entry.sv
// One issue-queue entry: stored source tags, valid bit and sticky per-operand ready bits.
module wakeup_cam_entry
  import wakeup_cam_ready_pkg::*;
#(
  parameter int unsigned RPORT = IqRport,
  parameter int unsigned WIDTH = IqWidth,
  parameter int unsigned NSRC  = IqNsrc
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [RPORT-1:0][WIDTH-1:0] tag_i,
  input  logic [RPORT-1:0]            tag_valid_i,
  input  logic                        wr_sel_i,
  input  logic [NSRC-1:0][WIDTH-1:0]  wr_tag_i,
  input  logic [NSRC-1:0]             wr_rdy_i,
  input  logic                        free_i,
  input  logic                        flush_i,
  output logic                        valid_o,
  output logic [NSRC-1:0]             src_rdy_o
);

  logic [NSRC-1:0][WIDTH-1:0] tag_q;
  logic                       valid_q, valid_d;
  logic [NSRC-1:0]            rdy_q, rdy_d;
  logic [NSRC-1:0]            wr_hit, st_hit;

  // wr_hit is the same-cycle bypass for tags being written now.
  always_comb begin
    wr_hit = '0;
    st_hit = '0;
    for (int s = 0; s < int'(NSRC); s++) begin
      for (int p = 0; p < int'(RPORT); p++) begin
        if (tag_valid_i[p] && (tag_i[p] == wr_tag_i[s])) wr_hit[s] = 1'b1;
        if (tag_valid_i[p] && (tag_i[p] == tag_q[s]))    st_hit[s] = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    rdy_d   = rdy_q;
    if (flush_i) begin
      valid_d = 1'b0;
      rdy_d   = '0;
    end else if (wr_sel_i) begin
      valid_d = 1'b1;
      rdy_d   = wr_rdy_i | wr_hit;
    end else if (free_i) begin
      valid_d = 1'b0;
      rdy_d   = '0;
    end else if (valid_q) begin
      rdy_d   = rdy_q | st_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      rdy_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
    end
  end

  // Tags carry no reset; they are only observed while valid_q is set.
  always_ff @(posedge clk) begin
    if (wr_sel_i) tag_q <= wr_tag_i;
  end

  assign valid_o   = valid_q;
  assign src_rdy_o = rdy_q;

endmodule

// File: rtl/wakeup_cam_ready.sv
// Issue-queue wakeup CAM: decodes dispatch writes to entries and exposes ready state to select.
module wakeup_cam_ready
  import wakeup_cam_ready_pkg::*;
#(
  parameter int unsigned RPORT = IqRport,
  parameter int unsigned WPORT = IqWport,
  parameter int unsigned DEPTH = IqDepth,
  parameter int unsigned INDEX = IqIndex,
  parameter int unsigned WIDTH = IqWidth,
  parameter int unsigned NSRC  = IqNsrc
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [RPORT-1:0][WIDTH-1:0]            tag_i,
  input  logic [RPORT-1:0]                       tagValid_i,
  input  logic [WPORT-1:0]                       we_i,
  input  logic [WPORT-1:0][INDEX-1:0]            wrAddr_i,
  input  logic [WPORT-1:0][NSRC-1:0][WIDTH-1:0]  wrTag_i,
  input  logic [WPORT-1:0][NSRC-1:0]             wrRdy_i,
  input  logic [DEPTH-1:0]                       freeVect_i,
  input  logic                                   flush_i,
  output logic [DEPTH-1:0]                       valid_o,
  output logic [DEPTH-1:0][NSRC-1:0]             srcRdy_o,
  output logic [DEPTH-1:0]                       entryRdy_o
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic                       wr_sel;
    logic [NSRC-1:0][WIDTH-1:0] wr_tag;
    logic [NSRC-1:0]            wr_rdy;

    // Ascending scan lets the highest-numbered matching port win.
    always_comb begin
      wr_sel = 1'b0;
      wr_tag = '0;
      wr_rdy = '0;
      for (int w = 0; w < int'(WPORT); w++) begin
        if (we_i[w] && (wrAddr_i[w] == INDEX'(i))) begin
          wr_sel = 1'b1;
          wr_tag = wrTag_i[w];
          wr_rdy = wrRdy_i[w];
        end
      end
    end

    wakeup_cam_entry #(
      .RPORT (RPORT),
      .WIDTH (WIDTH),
      .NSRC  (NSRC)
    ) u_entry (
      .clk         (clk),
      .reset       (reset),
      .tag_i       (tag_i),
      .tag_valid_i (tagValid_i),
      .wr_sel_i    (wr_sel),
      .wr_tag_i    (wr_tag),
      .wr_rdy_i    (wr_rdy),
      .free_i      (freeVect_i[i]),
      .flush_i     (flush_i),
      .valid_o     (valid_o[i]),
      .src_rdy_o   (srcRdy_o[i])
    );

    assign entryRdy_o[i] = valid_o[i] & (&srcRdy_o[i]);
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset) begin
      for (int w = 0; w < int'(WPORT); w++) begin
        if (we_i[w]) begin
          assert (32'(wrAddr_i[w]) < DEPTH)
            else $warning("wakeup_cam_ready: port %0d writes address %0d beyond depth",
                          w, wrAddr_i[w]);
          for (int v = w + 1; v < int'(WPORT); v++) begin
            if (we_i[v]) begin
              assert (wrAddr_i[w] != wrAddr_i[v])
                else $warning("wakeup_cam_ready: ports %0d and %0d both write entry %0d",
                              w, v, wrAddr_i[w]);
            end
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_wakeup_cam_ready.sv
// Directed bench for wakeup_cam_ready with a per-cycle reference model and literal spot checks.
module tb_wakeup_cam_ready;
  import wakeup_cam_ready_pkg::*;

  localparam int RP = IqRport;
  localparam int WP = IqWport;
  localparam int DP = IqDepth;
  localparam int IX = IqIndex;
  localparam int WD = IqWidth;
  localparam int NS = IqNsrc;

  logic                             clk = 1'b0;
  logic                             reset;
  logic [RP-1:0][WD-1:0]            tag_i;
  logic [RP-1:0]                    tagValid_i;
  logic [WP-1:0]                    we_i;
  logic [WP-1:0][IX-1:0]            wrAddr_i;
  logic [WP-1:0][NS-1:0][WD-1:0]    wrTag_i;
  logic [WP-1:0][NS-1:0]            wrRdy_i;
  logic [DP-1:0]                    freeVect_i;
  logic                             flush_i;
  logic [DP-1:0]                    valid_o;
  logic [DP-1:0][NS-1:0]            srcRdy_o;
  logic [DP-1:0]                    entryRdy_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  wakeup_cam_ready dut (
    .clk        (clk),
    .reset      (reset),
    .tag_i      (tag_i),
    .tagValid_i (tagValid_i),
    .we_i       (we_i),
    .wrAddr_i   (wrAddr_i),
    .wrTag_i    (wrTag_i),
    .wrRdy_i    (wrRdy_i),
    .freeVect_i (freeVect_i),
    .flush_i    (flush_i),
    .valid_o    (valid_o),
    .srcRdy_o   (srcRdy_o),
    .entryRdy_o (entryRdy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: entry state as plain arrays, updated by applying the rules in
  // ascending priority so that later steps override earlier ones.
  bit        m_valid [DP];
  bit        m_rdy   [DP][NS];
  phys_tag_t m_tag   [DP][NS];

  function automatic bit on_bus(input phys_tag_t t);
    for (int p = 0; p < RP; p++) if (tagValid_i[p] && tag_i[p] == t) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (reset || flush_i) begin
        for (int i = 0; i < DP; i++) begin
          m_valid[i] = 1'b0;
          for (int s = 0; s < NS; s++) m_rdy[i][s] = 1'b0;
        end
      end else begin
        for (int i = 0; i < DP; i++)
          if (m_valid[i])
            for (int s = 0; s < NS; s++) if (on_bus(m_tag[i][s])) m_rdy[i][s] = 1'b1;
        for (int i = 0; i < DP; i++)
          if (freeVect_i[i]) begin
            m_valid[i] = 1'b0;
            for (int s = 0; s < NS; s++) m_rdy[i][s] = 1'b0;
          end
        for (int w = 0; w < WP; w++)
          if (we_i[w] && int'(wrAddr_i[w]) < DP) begin
            m_valid[wrAddr_i[w]] = 1'b1;
            for (int s = 0; s < NS; s++) begin
              m_tag[wrAddr_i[w]][s] = wrTag_i[w][s];
              m_rdy[wrAddr_i[w]][s] = wrRdy_i[w][s] | on_bus(wrTag_i[w][s]);
            end
          end
      end
    end
  end

  initial begin
    logic [DP-1:0]         e_valid, e_er;
    logic [DP-1:0][NS-1:0] e_rdy;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < DP; i++) begin
          e_valid[i] = m_valid[i];
          e_er[i]    = m_valid[i];
          for (int s = 0; s < NS; s++) begin
            e_rdy[i][s] = m_rdy[i][s];
            e_er[i]     = e_er[i] & m_rdy[i][s];
          end
        end
        check("model valid_o", 64'(valid_o), 64'(e_valid));
        check("model srcRdy_o", 64'(srcRdy_o), 64'(e_rdy));
        check("model entryRdy_o", 64'(entryRdy_o), 64'(e_er));
      end
    end
  end

  task automatic idle();
    tag_i      = '0;
    tagValid_i = '0;
    we_i       = '0;
    wrAddr_i   = '0;
    wrTag_i    = '0;
    wrRdy_i    = '0;
    freeVect_i = '0;
    flush_i    = 1'b0;
  endtask

  task automatic bcast(input int p, input int t);
    tag_i[p]      = WD'(t);
    tagValid_i[p] = 1'b1;
  endtask

  task automatic wr(input int w, input int a, input int t0, input int t1, input logic [1:0] r);
    we_i[w]       = 1'b1;
    wrAddr_i[w]   = IX'(a);
    wrTag_i[w][0] = WD'(t0);
    wrTag_i[w][1] = WD'(t1);
    wrRdy_i[w]    = r;
  endtask

  // Apply current inputs on the next edge, then return to idle inputs 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    check("reset valid_o", 64'(valid_o), 64'd0);
    check("reset srcRdy_o", 64'(srcRdy_o), 64'd0);
    check("reset entryRdy_o", 64'(entryRdy_o), 64'd0);

    // Basic wakeup of entry 3.
    wr(0, 3, 10, 11, 2'b00);
    tick();
    check("basic valid[3]", 64'(valid_o[3]), 64'd1);
    check("basic rdy[3] after write", 64'(srcRdy_o[3]), 64'b00);
    tick();
    bcast(0, 10);
    tick();
    check("basic rdy[3] after tag 10", 64'(srcRdy_o[3]), 64'b01);
    check("basic entryRdy[3] half", 64'(entryRdy_o[3]), 64'd0);
    bcast(3, 11);
    tick();
    check("basic rdy[3] after tag 11", 64'(srcRdy_o[3]), 64'b11);
    check("basic entryRdy[3]", 64'(entryRdy_o[3]), 64'd1);

    // Dispatch/broadcast bypass.
    wr(1, 5, 20, 21, 2'b10);
    bcast(2, 20);
    tick();
    check("bypass entryRdy[5]", 64'(entryRdy_o[5]), 64'd1);

    // Qualifier off, then broadcast to a freed entry.
    wr(0, 7, 30, 31, 2'b10);
    wr(1, 8, 30, 30, 2'b00);
    tick();
    tag_i[0]      = WD'(30);
    freeVect_i[8] = 1'b1;
    tick();
    check("qualifier rdy[7]", 64'(srcRdy_o[7]), 64'b10);
    check("freed valid[8]", 64'(valid_o[8]), 64'd0);
    bcast(1, 30);
    tick();
    check("freed rdy[8]", 64'(srcRdy_o[8]), 64'b00);
    check("wake entryRdy[7]", 64'(entryRdy_o[7]), 64'd1);

    // Write beats free on entry 9; new tags take effect.
    wr(2, 9, 40, 41, 2'b00);
    tick();
    wr(3, 9, 42, 43, 2'b00);
    freeVect_i[9] = 1'b1;
    tick();
    check("write>free valid[9]", 64'(valid_o[9]), 64'd1);
    bcast(0, 40);
    bcast(1, 41);
    tick();
    check("old tags rdy[9]", 64'(srcRdy_o[9]), 64'b00);
    bcast(2, 42);
    tick();
    check("new tag rdy[9]", 64'(srcRdy_o[9]), 64'b01);

    // Two ports writing entry 4: port 2 wins.
    wr(0, 4, 50, 51, 2'b00);
    wr(2, 4, 52, 53, 2'b00);
    tick();
    check("dup write valid[4]", 64'(valid_o[4]), 64'd1);
    bcast(0, 50);
    bcast(1, 51);
    tick();
    check("dup write port0 tags", 64'(srcRdy_o[4]), 64'b00);
    bcast(0, 52);
    bcast(1, 53);
    tick();
    check("dup write port2 tags", 64'(entryRdy_o[4]), 64'd1);

    // Eight partially-ready entries, then flush with a matching broadcast.
    for (int k = 0; k < 4; k++) wr(k, 16 + k, 60 + k, 70 + k, (k % 2 == 1) ? 2'b01 : 2'b00);
    tick();
    for (int k = 4; k < 8; k++) wr(k - 4, 16 + k, 60 + k, 70 + k, (k % 2 == 1) ? 2'b01 : 2'b00);
    tick();
    for (int p = 0; p < RP; p++) bcast(p, 60);
    tick();
    check("pre-flush rdy[16]", 64'(srcRdy_o[16]), 64'b01);
    flush_i = 1'b1;
    for (int p = 0; p < RP; p++) bcast(p, 70 + p);
    tick();
    check("flush valid_o", 64'(valid_o), 64'd0);
    check("flush srcRdy_o", 64'(srcRdy_o), 64'd0);
    check("flush entryRdy_o", 64'(entryRdy_o), 64'd0);
    wr(0, 16, 1, 2, 2'b11);
    tick();
    check("post-flush valid_o", 64'(valid_o), 64'h0001_0000);
    check("post-flush entryRdy_o", 64'(entryRdy_o), 64'h0001_0000);

    // Reset mid-operation discards a same-cycle write and wakeup.
    wr(1, 2, 5, 6, 2'b11);
    bcast(0, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid reset valid_o", 64'(valid_o), 64'd0);
    check("mid reset srcRdy_o", 64'(srcRdy_o), 64'd0);
    tick();
    tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wakeup_cam_ready.md
# wakeup_cam_ready

Parametrised issue-queue wakeup CAM with per-entry valid and per-operand ready state, replacing the ifdef-per-port wakeup CAM. It sits between dispatch and select in the issue queue:
- Dispatch writes entries holding NSRC source tags.
- Up to RPORT result tags are broadcast each cycle.
- The block accumulates registered ready bits and presents a per-entry request vector to select.
- Adds over the old CAM: valid tracking, sticky ready bits, same-cycle dispatch/broadcast bypass, entry free and flush.

## Interface
Parameters:
- RPORT, 4, number of tag broadcast (issue) ports
- WPORT, 4, number of dispatch write ports
- DEPTH, 32, number of entries
- INDEX, 5, entry address width; must satisfy 2^INDEX >= DEPTH
- WIDTH, 7, physical tag width
- NSRC, 2, source operands per entry

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- tag_i  in  RPORT x WIDTH  broadcast result tags
- tagValid_i  in  RPORT  per-port broadcast qualifier
- we_i  in  WPORT  per-port dispatch write enable
- wrAddr_i  in  WPORT x INDEX  entry written by each port
- wrTag_i  in  WPORT x NSRC x WIDTH  source tags of the new entry
- wrRdy_i  in  WPORT x NSRC  operand already ready at dispatch
- freeVect_i  in  DEPTH  entries to invalidate (issued or squashed)
- flush_i  in  1  invalidate all entries
- valid_o  out  DEPTH  entry valid (registered)
- srcRdy_o  out  DEPTH x NSRC  operand ready (registered)
- entryRdy_o  out  DEPTH  valid_o[i] AND all srcRdy_o[i][*] (combinational from registers only)

## Operation
- Match term: match(t, i, s) = tagValid_i[p] AND tag_i[p] == t, for any p. Ports with tagValid_i = 0 never match.
- Wakeup:
  - Applies to every valid entry i and operand s with srcRdy clear.
  - If match(storedTag[i][s]) holds, srcRdy[i][s] is set at the next edge.
  - Ready bits are sticky until the entry is rewritten, freed or flushed.
- Write (port w, we_i[w] = 1):
  - Next cycle: valid[wrAddr] = 1 and storedTag = wrTag_i.
  - srcRdy[s] = wrRdy_i[w][s] OR match(wrTag_i[w][s]) in the same cycle. This bypass prevents a missed wakeup.
- Free: freeVect_i[i] = 1 clears valid[i] and srcRdy[i][*].
- Flush: clears all valid and srcRdy bits.
- Priority per entry, highest first: reset > flush > write > free > wakeup.
  - Write and free to the same entry in the same cycle: the write wins.
  - Two write ports to the same address: the highest port index wins. This is illegal upstream; the assertion below is kept active in simulation only.
- Invalid entries:
  - Never wake up.
  - srcRdy_o stays 0.
  - entryRdy_o stays 0.
- Duplicate broadcast tags across ports are legal; the result is the same as a single match.
- Stored tags are not reset. No output depends on a stored tag while valid = 0.
- Entries with wrAddr >= DEPTH are ignored; assertion in simulation.

## Timing
- Reset: valid_o, srcRdy_o and entryRdy_o are all 0 on the cycle after reset is sampled high. reset asserted mid-operation discards all in-flight writes and wakeups in that cycle.
- Broadcast in cycle t: srcRdy_o and entryRdy_o reflect it from cycle t+1.
- Dispatch write in cycle t: valid_o is set at t+1. entryRdy_o can be 1 at t+1 if all operands were ready or bypass-woken.
- Free or flush in cycle t: outputs cleared at t+1. A broadcast in the same cycle has no effect on a freed entry.
- Throughput: WPORT writes, RPORT broadcasts and any free vector every cycle, with no stalls. Full/empty accounting belongs to the free list, not this block.

## Structure
- Shared package (the issue queue package) holds `phys_tag_t` (WIDTH bits), `iq_index_t` (INDEX bits), and the default RPORT/WPORT/DEPTH/NSRC constants.
- Sub-module `wakeup_cam_entry`, instantiated DEPTH times. Each instance holds one entry's tags, valid and ready bits, compares against all RPORT tags, and receives its own write-select, data mux and free bit. The top level decodes write ports to per-entry selects, applying highest-port-wins.
- Port lists are arrays sized by parameters. No per-width ifdefs.

## Test plan
- Reset then idle: assert reset 1 cycle, then 0 → valid_o = 0, srcRdy_o = 0, entryRdy_o = 0; tags X tolerated internally.
- Basic wakeup:
  - Stimulus: write entry 3 with tags {10, 11}, wrRdy = {0, 0}; cycle+2 broadcast 10 on port 0; cycle+3 broadcast 11 on port 3.
  - Response: srcRdy_o[3] = 01 after the first broadcast, 11 after the second; entryRdy_o[3] = 1 one cycle after tag 11.
- Bypass: write entry 5 with tags {20, 21}, wrRdy = {0, 1}, and broadcast 20 in the same cycle → next cycle entryRdy_o[5] = 1.
- Qualifier and invalid entry: broadcast 30 with tagValid_i = 0 while entry 7 waits on 30 → no wakeup. Broadcast 30 valid to a freed entry holding 30 → srcRdy_o stays 0.
- Priority:
  - Write and free to entry 9 in the same cycle → valid_o[9] = 1 with new tags.
  - Ports 0 and 2 both write entry 4 → port 2 tags stored, and the assertion fires.
- Flush mid-operation: 8 valid partially-ready entries; flush_i plus a matching broadcast in the same cycle → all outputs 0 next cycle. The following write behaves normally.
